reg_access_arbiter: RTL
=======================

# reg_access_arbiter

Round-robin arbiter that shares one 3-bit-controlled register (commands NONE/CLR/LOAD/INCR/DECR) among NUM_REQ requesters. It accepts one command per transaction over a valid/ready handshake and drives the register's ctrl/data_input for exactly one cycle. It then returns the post-operation register value tagged with the requester ID. An optional lock lets one requester issue a bounded burst of back-to-back operations.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..8
- DATA_WIDTH, 8, register data width
- LOCK_MAX, 4, maximum consecutive locked transactions per owner; legal range 1..15
- ID_WIDTH (localparam), max(1, clog2(NUM_REQ))
- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous, active-low reset
- req_valid  in  NUM_REQ  request valid, one bit per requester
- req_cmd  in  3*NUM_REQ  command for requester i at bits [3i+2:3i]
- req_data  in  DATA_WIDTH*NUM_REQ  LOAD data for requester i
- req_lock  in  NUM_REQ  keep ownership after this transaction
- req_ready  out  NUM_REQ  one-hot accept; transfer on valid&ready
- reg_ctrl  out  3  to register ctrl
- reg_data  out  DATA_WIDTH  to register data_input
- reg_value  in  DATA_WIDTH  register data_output
- rsp_valid  out  1  one-cycle response strobe
- rsp_id  out  ID_WIDTH  index of the requester whose operation completed
- rsp_data  out  DATA_WIDTH  register value after the operation

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Candidates are all req_valid bits. If a lock is held, the only candidate is the owner.
  - The winner is the first candidate found searching upward from rr_ptr, wrapping at NUM_REQ-1 to 0.
  - req_ready[winner]=1, combinational and only in IDLE.
  - On transfer: latch cmd, data, lock and winner ID; go to ISSUE.
  - No candidate: stay in IDLE with req_ready=0.
- ISSUE:
  - Drive reg_ctrl=latched cmd and reg_data=latched data for exactly this cycle. The register updates on the closing edge.
  - Go to RESP.
- RESP:
  - rsp_valid=1, rsp_data=reg_value, rsp_id=latched ID.
  - Update rr_ptr to (ID+1) mod NUM_REQ, including during locked bursts.
  - Update the lock (rules below), then go to IDLE.
- Command handling:
  - Codes 0–4 are forwarded unchanged.
  - Codes 5–7 are illegal. They are forwarded as NONE (0), still handshaked, and the response returns the unchanged value.
- reg_ctrl=0 and reg_data=0 in every state other than ISSUE.
- Lock rules:
  - In RESP, if the latched lock=1 and lock_cnt+1 < LOCK_MAX: owner=ID, lock_cnt increments.
  - Otherwise the lock is released and lock_cnt=0.
  - A locked owner that deasserts req_valid keeps the lock. The arbiter idles waiting for that owner; there is no timeout.
- Arithmetic:
  - lock_cnt is 4 bits.
  - rr_ptr is ID_WIDTH bits; wrap is explicit, not modulo 2^ID_WIDTH.
  - INCR/DECR wrap-around is the register's behaviour; the arbiter does not check it.

## Timing
- Latency from accept edge to rsp_valid is 2 cycles.
- Unlocked throughput is one transaction per 3 cycles. A locked burst also runs at 3 cycles per operation, but no other requester can interleave.
- Any requester is granted within NUM_REQ transactions when no lock is held. With locks, the bound is NUM_REQ*LOCK_MAX transactions.
- Requesters must hold req_cmd, req_data and req_lock stable while req_valid=1 and req_ready=0. Dropping valid before ready is legal: it withdraws the request.
- Reset, sampled while rst=0 at posedge:
  - State=IDLE, rr_ptr=0, lock released, lock_cnt=0, latched fields 0.
  - While rst=0: req_ready=0, reg_ctrl=0, reg_data=0, rsp_valid=0, rsp_id=0, rsp_data=0.
  - Reset in ISSUE or RESP aborts the transaction with no response. The register is reset by the same rst.
- Simultaneous events:
  - A new req_valid arriving during ISSUE or RESP waits for IDLE.
  - A lock owner re-requesting in IDLE wins even if a lower index is pending.

## Test plan
- Single request: requester 2 issues LOAD 0x5A. Required: req_ready[2] in cycle 0, reg_ctrl=2 and reg_data=0x5A in cycle 1, then rsp_valid with id=2 and data=0x5A in cycle 2.
- All four requesters hold INCR continuously from reset. Required: grants in order 0,1,2,3,0; rsp_data=1,2,3,4,5; one response every 3 cycles.
- Requester 1 issues INCR with lock=1 continuously while requester 0 also requests, LOCK_MAX=4. Required: four consecutive grants to 1, then a grant to 0.
- Illegal cmd 7 from requester 3 when the value is 0x10. Required: reg_ctrl=0 during ISSUE, response id=3 with data=0x10.
- DECR from 0x00. Required: rsp_data=0xFF.
- Reset wrap-around: assert rst=0 during ISSUE. Required: no rsp_valid, all outputs 0 and rr_ptr=0 next cycle. After release, requester 0 is granted first.

Source files
------------

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter sharing one NONE/CLR/LOAD/INCR/DECR register among NUM_REQ requesters,
// with a bounded per-owner lock for back-to-back bursts.
module reg_access_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int LOCK_MAX   = 4,
    localparam int ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [3*NUM_REQ-1:0]         req_cmd,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_lock,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [2:0]                   reg_ctrl,
    output logic [DATA_WIDTH-1:0]        reg_data,
    input  logic [DATA_WIDTH-1:0]        reg_value,
    output logic                         rsp_valid,
    output logic [ID_WIDTH-1:0]          rsp_id,
    output logic [DATA_WIDTH-1:0]        rsp_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                state, state_d;
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic                  lock_held;
    logic [ID_WIDTH-1:0]   owner;
    logic [3:0]            lock_cnt;
    logic [2:0]            cmd_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  lock_q;
    logic [ID_WIDTH-1:0]   id_q;

    logic [NUM_REQ-1:0]    cand;
    logic [ID_WIDTH-1:0]   idx;
    logic [ID_WIDTH-1:0]   win;
    logic                  found;
    logic                  take;
    logic [2:0]            sel_cmd;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_lock;

    // Winner search: first candidate at or above rr_ptr, wrapping at NUM_REQ-1 back to 0.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cand     = req_valid;
        idx      = '0;
        win      = '0;
        found    = 1'b0;
        sel_cmd  = '0;
        sel_data = '0;
        sel_lock = 1'b0;
        if (lock_held) begin
            for (int i = 0; i < NUM_REQ; i++)
                cand[i] = req_valid[i] && (owner == ID_WIDTH'(i));
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (int'(rr_ptr) + k >= NUM_REQ)
                idx = ID_WIDTH'(int'(rr_ptr) + k - NUM_REQ);
            else
                idx = ID_WIDTH'(int'(rr_ptr) + k);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == ID_WIDTH'(i)) begin
                sel_cmd  = req_cmd[3*i +: 3];
                sel_data = req_data[DATA_WIDTH*i +: DATA_WIDTH];
                sel_lock = req_lock[i];
            end
        end
    end

    // Next state and outputs; every output is forced low while reset is asserted.
    always_comb begin
        state_d   = state;
        req_ready = '0;
        reg_ctrl  = '0;
        reg_data  = '0;
        rsp_valid = 1'b0;
        rsp_id    = '0;
        rsp_data  = '0;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (found && rst) begin
                    for (int i = 0; i < NUM_REQ; i++)
                        req_ready[i] = (win == ID_WIDTH'(i));
                    take    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (rst) begin
                    reg_ctrl = cmd_q;
                    reg_data = data_q;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rst) begin
                    rsp_valid = 1'b1;
                    rsp_id    = id_q;
                    rsp_data  = reg_value;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            lock_held <= 1'b0;
            owner     <= '0;
            lock_cnt  <= '0;
            cmd_q     <= '0;
            data_q    <= '0;
            lock_q    <= 1'b0;
            id_q      <= '0;
        end else begin
            state <= state_d;
            if (take) begin
                // Illegal codes 5..7 become NONE so the register holds its value.
                cmd_q  <= (sel_cmd > 3'd4) ? 3'd0 : sel_cmd;
                data_q <= sel_data;
                lock_q <= sel_lock;
                id_q   <= win;
            end
            if (state == RESP) begin
                rr_ptr <= (int'(id_q) == NUM_REQ - 1) ? '0 : id_q + ID_WIDTH'(1);
                if (lock_q && ({1'b0, lock_cnt} + 5'd1 < 5'(LOCK_MAX))) begin
                    lock_held <= 1'b1;
                    owner     <= id_q;
                    lock_cnt  <= lock_cnt + 4'd1;
                end else begin
                    lock_held <= 1'b0;
                    lock_cnt  <= '0;
                end
            end
        end
    end

endmodule
